dsp_op_scheduler: RTL

DSP_OP_SCHEDULER -- requirements
Module: dsp_op_scheduler

---
 rtl/dsp_op_scheduler.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dsp_op_scheduler.sv
// dsp_op_scheduler
//   Arbitrates two requesters onto a single multi-cycle DSP multiply/add unit.
//   One operation is in flight at a time. A round-robin grant latches the
//   operands, HOLD waits for the DSP start-to-start gap, RUN issues the
//   operation, and the result is captured on the last RUN cycle.
//   Mode 11 requests are rejected with an error result and are never issued.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     per-requester request / one-cycle accept pulse
//   req_mode/a/b/c      per-requester mode and operands (packed, requester 1 high)
//   req_mac/shift       per-requester accumulate-select and accumulator shift
//   dsp_*               drive side of the DSP (start, mode, operands)
//   dsp_out             DSP result
//   dsp_compare_res     DSP result-valid strobe, sampled in the capture cycle
//   res_valid/id/data   one-cycle result pulse, requester index, captured data
//   res_err             set for rejected requests or a missing result strobe
module dsp_op_scheduler #(
  parameter int N = 9,
  parameter int M = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [3:0]         req_mode,
  input  logic [2*N-1:0]     req_a,
  input  logic [2*M-1:0]     req_b,
  input  logic [2*(N+M)-1:0] req_c,
  input  logic [1:0]         req_mac,
  input  logic [3:0]         req_shift,
  output logic               dsp_start,
  output logic [1:0]         dsp_mode,
  output logic [N-1:0]       dsp_aa,
  output logic [M-1:0]       dsp_bb,
  output logic [N+M-1:0]     dsp_cc,
  output logic               dsp_mac,
  output logic [1:0]         dsp_shift,
  input  logic [N+M-1:0]     dsp_out,
  input  logic               dsp_compare_res,
  output logic               res_valid,
  output logic               res_id,
  output logic [N+M-1:0]     res_data,
  output logic               res_err
);

  localparam int W = N + M;

  typedef enum logic [1:0] {IDLE, HOLD, RUN} state_t;

  state_t         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic           id_q, id_d;
  logic [1:0]     mode_q, mode_d;
  logic [N-1:0]   a_q, a_d;
  logic [M-1:0]   b_q, b_d;
  logic [W-1:0]   c_q, c_d;
  logic           mac_q, mac_d;
  logic [1:0]     shift_q, shift_d;
  logic [2:0]     gap_q, gap_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           first_q, first_d;
  logic           res_valid_q, res_valid_d;
  logic           res_id_q, res_id_d;
  logic [W-1:0]   res_data_q, res_data_d;
  logic           res_err_q, res_err_d;

  logic           grant;
  logic           gidx;
  logic [1:0]     gmode;
  logic           hold_ok;

  // Grant decision: only in IDLE; on contention the pointer picks the winner.
  assign grant = (state_q == IDLE) && (req_valid != 2'b00);
  assign gidx  = (req_valid == 2'b11) ? ptr_q : req_valid[1];
  assign gmode = gidx ? req_mode[3:2] : req_mode[1:0];

  // gap_q counts cycles since the last start as of this cycle; the start
  // would happen next cycle, so the gap then is gap_q + 1.
  always_comb begin
    hold_ok = 1'b1;
    if (mode_q == 2'b10)      hold_ok = (gap_q >= 3'd3);
    else if (mode_q == 2'b01) hold_ok = (gap_q >= 3'd1);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    mac_d       = mac_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    first_d     = 1'b0;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    dsp_start   = (state_q == RUN) && first_q;
    gap_d       = dsp_start ? 3'd1 : ((gap_q == 3'd7) ? 3'd7 : gap_q + 3'd1);

    case (state_q)
      IDLE: begin
        if (grant) begin
          ptr_d   = ~gidx;
          id_d    = gidx;
          mode_d  = gmode;
          a_d     = gidx ? req_a[2*N-1:N]     : req_a[N-1:0];
          b_d     = gidx ? req_b[2*M-1:M]     : req_b[M-1:0];
          c_d     = gidx ? req_c[2*W-1:W]     : req_c[W-1:0];
          mac_d   = gidx ? req_mac[1]         : req_mac[0];
          shift_d = gidx ? req_shift[3:2]     : req_shift[1:0];
          if (gmode == 2'b11) begin
            // Illegal mode: answer with an error next cycle, never issue it.
            res_valid_d = 1'b1;
            res_id_d    = gidx;
            res_data_d  = '0;
            res_err_d   = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (hold_ok) begin
          state_d = RUN;
          first_d = 1'b1;
          case (mode_q)
            2'b01:   cnt_d = 2'd1;
            2'b10:   cnt_d = 2'd3;
            default: cnt_d = 2'd0;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == 2'd0) begin
          state_d     = IDLE;
          res_valid_d = 1'b1;
          res_id_d    = id_q;
          res_data_d  = dsp_out;
          res_err_d   = ~dsp_compare_res;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      mode_q      <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      mac_q       <= 1'b0;
      shift_q     <= 2'b00;
      gap_q       <= 3'd7;
      cnt_q       <= 2'd0;
      first_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      mac_q       <= mac_d;
      shift_q     <= shift_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  // Ready is combinational from IDLE state; masked so reset silences it at once.
  assign req_ready = (grant ? (gidx ? 2'b10 : 2'b01) : 2'b00) & {2{rst_n}};

  // Outside RUN the DSP sees mode 11 so its accumulator holds.
  assign dsp_mode  = (state_q == RUN) ? mode_q : 2'b11;
  assign dsp_aa    = a_q;
  assign dsp_bb    = b_q;
  assign dsp_cc    = c_q;
  assign dsp_mac   = mac_q;
  assign dsp_shift = shift_q;

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule
